// File: rtl/caesar_rev_search.sv
// caesar_rev_search: inverse lookup over the packed 26-entry substitution table.
// Returns the lowest index whose entry equals the query character, with
// valid/ready handshakes on both sides.
//
// Build option: define CAESAR_REV_FAST_EN to compare all entries in parallel
// (one SCAN cycle per query). Without it, SCAN walks one entry per cycle.
module caesar_rev_search #(
  parameter int unsigned N_ENTRIES = 26,
  parameter int unsigned W         = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [N_ENTRIES*W-1:0] idx_in,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [W-1:0]           in_char,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [4:0]             out_idx,
  output logic                   out_found
);

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StScan = 2'd1;
  localparam logic [1:0] StDone = 2'd2;

  localparam logic [4:0] LastPtr = 5'(N_ENTRIES - 1);

  logic [1:0]             state_q, state_d;
  logic [4:0]             ptr_q, ptr_d;
  logic [W-1:0]           char_q, char_d;
  logic [N_ENTRIES*W-1:0] table_q, table_d;
  logic [4:0]             out_idx_q, out_idx_d;
  logic                   out_found_q, out_found_d;

  // Latched table split into slots; slot 0 is the top W bits.
  logic [W-1:0] entry [N_ENTRIES];

  // Result of the current SCAN cycle's comparison.
  logic       hit;
  logic [4:0] hit_idx;
  logic       scan_last;

  // Unpack the latched table into per-index entries.
  always_comb begin
    for (int unsigned k = 0; k < N_ENTRIES; k++) begin
      entry[k] = table_q[N_ENTRIES*W-1-k*W -: W];
    end
  end

`ifdef CAESAR_REV_FAST_EN
  // Parallel compare; walking downward leaves the lowest matching index.
  always_comb begin
    hit     = 1'b0;
    hit_idx = '0;
    for (int k = int'(N_ENTRIES) - 1; k >= 0; k--) begin
      if (entry[k] == char_q) begin
        hit     = 1'b1;
        hit_idx = 5'(k);
      end
    end
    // The whole table is covered in one cycle, so every SCAN is final.
    scan_last = 1'b1;
  end
`else
  // Serial compare of the slot selected by ptr.
  always_comb begin
    hit       = (entry[ptr_q] == char_q);
    hit_idx   = ptr_q;
    scan_last = (ptr_q == LastPtr);
  end
`endif

  // Next-state and datapath update.
  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    char_d      = char_q;
    table_d     = table_q;
    out_idx_d   = out_idx_q;
    out_found_d = out_found_q;

    unique case (state_q)
      StIdle: begin
        if (in_valid) begin
          // Snapshot the table so later idx_in changes cannot affect this query.
          char_d  = in_char;
          table_d = idx_in;
          ptr_d   = '0;
          state_d = StScan;
        end
      end

      StScan: begin
        if (hit) begin
          out_idx_d   = hit_idx;
          out_found_d = 1'b1;
          state_d     = StDone;
        end else if (scan_last) begin
          out_idx_d   = '0;
          out_found_d = 1'b0;
          state_d     = StDone;
        end else begin
`ifndef CAESAR_REV_FAST_EN
          ptr_d = ptr_q + 5'd1;
`endif
        end
      end

      StDone: begin
        // Return to IDLE only; the next query is taken a cycle later.
        if (out_ready) begin
          state_d = StIdle;
        end
      end

      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // State registers with synchronous active-high reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      ptr_q       <= '0;
      char_q      <= '0;
      table_q     <= '0;
      out_idx_q   <= '0;
      out_found_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      char_q      <= char_d;
      table_q     <= table_d;
      out_idx_q   <= out_idx_d;
      out_found_q <= out_found_d;
    end
  end

  // Handshake outputs decoded from registered state only.
  always_comb begin
    in_ready  = (state_q == StIdle);
    out_valid = (state_q == StDone);
    out_idx   = out_idx_q;
    out_found = out_found_q;
  end

endmodule

// File: tb/tb_caesar_rev_search.sv
// Self-checking bench for caesar_rev_search: directed cases plus randomized
// tables and queries compared against a behavioural lookup model.
module tb_caesar_rev_search;

  localparam int N = 26;
  localparam int W = 8;

`ifdef CAESAR_REV_FAST_EN
  localparam bit Fast = 1'b1;
`else
  localparam bit Fast = 1'b0;
`endif

  typedef logic [W-1:0] tbl_t [N];

  logic           clk = 1'b0;
  logic           rst;
  logic [N*W-1:0] idx_in;
  logic           in_valid;
  logic           in_ready;
  logic [W-1:0]   in_char;
  logic           out_valid;
  logic           out_ready;
  logic [4:0]     out_idx;
  logic           out_found;

  int n_tests = 0;
  int n_fail  = 0;

  caesar_rev_search #(
    .N_ENTRIES(N),
    .W        (W)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .idx_in   (idx_in),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_char  (in_char),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_idx  (out_idx),
    .out_found(out_found)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Entry k occupies the k-th byte counting down from the top of the bus.
  function automatic logic [N*W-1:0] pack(input tbl_t t);
    logic [N*W-1:0] p;
    for (int k = 0; k < N; k++) p[(N-1-k)*W +: W] = t[k];
    return p;
  endfunction

  // Reference: first index holding c, or not-found with index 0.
  function automatic void model(input tbl_t t, input logic [W-1:0] c,
                                output int idx, output bit found, output int lat);
    idx   = 0;
    found = 1'b0;
    for (int k = 0; k < N; k++) begin
      if (!found && t[k] == c) begin
        idx   = k;
        found = 1'b1;
      end
    end
    if (Fast) lat = 1;
    else      lat = found ? idx + 1 : N;
  endfunction

  // One full transaction: accept, scramble idx_in, wait for result,
  // hold out_ready low for 'hold' cycles, then release.
  task automatic run_query(input tbl_t t, input logic [W-1:0] c, input int hold,
                           input string tag);
    int exp_idx, exp_lat, lat;
    bit exp_found;
    model(t, c, exp_idx, exp_found, exp_lat);

    @(negedge clk);
    check({tag, "_in_ready"}, 32'(in_ready), 32'd1);
    in_valid  = 1'b1;
    in_char   = c;
    idx_in    = pack(t);
    out_ready = 1'b0;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    idx_in   = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    in_char  = W'($urandom);

    lat = 0;
    while (!out_valid && lat < 60) begin
      @(posedge clk);
      #1;
      lat++;
    end
    check({tag, "_latency"}, 32'(lat), 32'(exp_lat));
    check({tag, "_idx"}, 32'(out_idx), 32'(exp_idx));
    check({tag, "_found"}, 32'(out_found), 32'(exp_found));

    for (int i = 0; i < hold; i++) begin
      @(posedge clk);
      #1;
      check({tag, "_hold_valid"}, 32'(out_valid), 32'd1);
      check({tag, "_hold_idx"}, 32'(out_idx), 32'(exp_idx));
      check({tag, "_hold_found"}, 32'(out_found), 32'(exp_found));
      check({tag, "_hold_in_ready"}, 32'(in_ready), 32'd0);
    end

    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    check({tag, "_release_valid"}, 32'(out_valid), 32'd0);
    check({tag, "_release_in_ready"}, 32'(in_ready), 32'd1);
  endtask

  initial begin
    tbl_t ident, dup, rnd;
    logic [W-1:0] c;

    rst       = 1'b1;
    idx_in    = '0;
    in_valid  = 1'b0;
    in_char   = '0;
    out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    check("reset_in_ready", 32'(in_ready), 32'd1);
    check("reset_out_valid", 32'(out_valid), 32'd0);
    check("reset_out_idx", 32'(out_idx), 32'd0);
    check("reset_out_found", 32'(out_found), 32'd0);

    for (int k = 0; k < N; k++) ident[k] = W'(8'h41 + k);
    for (int k = 0; k < N; k++) dup[k] = W'(8'h61 + k);
    dup[3]  = 8'h51;
    dup[17] = 8'h51;

    run_query(ident, 8'h41, 0, "first_A");
    run_query(ident, 8'h5A, 0, "last_Z");
    run_query(ident, 8'h3F, 0, "miss");
    run_query(dup, 8'h51, 1, "dup_lowest");
    run_query(ident, 8'h41, 5, "backpressure");
    run_query(ident, 8'h4D, 0, "back_to_back");

    // Abort a query mid-scan (or in DONE for the parallel build) with reset.
    @(negedge clk);
    in_valid = 1'b1;
    in_char  = 8'h5A;
    idx_in   = pack(ident);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    check("abort_out_valid", 32'(out_valid), 32'd0);
    check("abort_in_ready", 32'(in_ready), 32'd1);
    check("abort_out_idx", 32'(out_idx), 32'd0);
    check("abort_out_found", 32'(out_found), 32'd0);
    repeat (3) @(posedge clk);
    #1;
    check("abort_no_result", 32'(out_valid), 32'd0);
    run_query(ident, 8'h42, 0, "after_abort");

    // Narrow alphabet forces duplicates and occasional misses.
    for (int n = 0; n < 40; n++) begin
      for (int k = 0; k < N; k++) rnd[k] = W'(8'h40 + $urandom_range(0, 11));
      c = W'(8'h40 + $urandom_range(0, 13));
      run_query(rnd, c, int'($urandom_range(0, 3)), $sformatf("rand%0d", n));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/caesar_rev_search.md
# caesar_rev_search

Sequential inverse lookup for the 26-entry substitution table used by the cipher datapath. The forward path maps an index to an 8-bit character by selecting one table slot. This block does the reverse: given an 8-bit character, it scans the same packed table and returns the lowest index whose entry matches. It sits on the return path of a rotor stage and uses a valid/ready handshake on both sides.

## Interface
Parameters:
- N_ENTRIES, 26, number of table slots.
- W, 8, width of each table entry and of the query character.

Ports:
- clk  in  1  rising-edge clock; the only clock.
- rst  in  1  reset, synchronous, active-high.
- idx_in  in  N_ENTRIES*W  packed table; entry k is bits [N_ENTRIES*W-1-k*W -: W], so entry 0 is the top byte [207:200].
- in_valid  in  1  query present.
- in_ready  out  1  block can accept a query.
- in_char  in  W  character to look up.
- out_valid  out  1  result present.
- out_ready  in  1  downstream accepts the result.
- out_idx  out  5  matching index, 0..N_ENTRIES-1.
- out_found  out  1  1 = match found; 0 = no entry matched.

## Operation
- FSM states: IDLE, SCAN, DONE. Reset state is IDLE.
- in_ready = (state == IDLE). out_valid = (state == DONE). Both are decoded from registered state.
- IDLE:
  - Query accepted on in_valid & in_ready.
  - On accept: latch in_char and the whole idx_in into internal registers, clear ptr (5 bits) to 0, go to SCAN.
  - idx_in changes after acceptance have no effect on that query.
- SCAN, one entry compared per cycle against the latched char:
  - Match at ptr: out_idx <= ptr, out_found <= 1, go to DONE.
  - No match and ptr == N_ENTRIES-1: out_idx <= 0, out_found <= 0, go to DONE.
  - Otherwise ptr <= ptr+1.
- Duplicate entries: the lowest index wins, because the scan ascends from 0.
- DONE:
  - out_idx and out_found stay stable while out_valid=1 and out_ready=0.
  - On out_ready: go to IDLE.
  - No new query is accepted in the same cycle (one bubble cycle).
- ptr never exceeds N_ENTRIES-1 and never wraps.
- Reset values: state IDLE, ptr 0, out_idx 0, out_found 0, out_valid 0, in_ready 1. Latched char and table are cleared to 0.
- rst asserted in any state, including mid-SCAN or DONE with out_ready=0, aborts the query. No result is produced. The next cycle is IDLE with reset values.

## Timing
- Accept edge is cycle 0. A match at index k gives out_valid=1 after edge k+1 (serial build).
- A miss gives out_valid after edge N_ENTRIES (26).
- Minimum query-to-query period: 1 (accept) + scan cycles + 1 (DONE with out_ready=1).
- No combinational path from in_valid to in_ready, or from out_ready to out_valid.

## Configuration
- CAESAR_REV_FAST_EN defined:
  - SCAN compares all N_ENTRIES entries in parallel and priority-encodes the lowest match.
  - SCAN always lasts exactly one cycle, so out_valid is high after edge 1 for every query, hit or miss.
  - ptr is unused and stays 0.
- CAESAR_REV_FAST_EN undefined: the serial scan above.
- Port list, handshake and results are identical in both builds; only latency differs.

## Test plan
- Table: entry k = 0x41+k (identity 'A'..'Z'). Query 0x41 -> out_idx=0, out_found=1, out_valid after edge 1.
- Same table, query 0x5A -> out_idx=25, out_found=1, out_valid after edge 26 (serial) or edge 1 (FAST).
- Same table, query 0x3F -> out_found=0, out_idx=0, out_valid after edge 26 (serial) or edge 1 (FAST).
- Table with entries 3 and 17 both 0x51, query 0x51 -> out_idx=3, out_found=1. Change idx_in right after accept -> result unchanged.
- Backpressure: hold out_ready=0 for 5 cycles in DONE -> out_valid, out_idx, out_found stable and in_ready=0 throughout. Raise out_ready -> IDLE next cycle, in_ready=1, back-to-back query accepted.
- Assert rst at scan cycle 10 of a query for 0x5A -> next cycle state IDLE, out_valid=0, in_ready=1, out_idx=0. A fresh query for 0x42 then returns out_idx=1.
